// File: rtl/llsc_pkg.sv
// Shared types for the LL/SC reservation table: op encoding, entry layout and LSQ opcode mapping.
// Entry fields are sized to the widest supported thread id and tag; narrower configs zero-extend.
package llsc_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_LL  = 2'd1,
    OP_SC  = 2'd2,
    OP_ST  = 2'd3
  } llsc_op_t;

  localparam int LLSC_TID_W_MAX = 4;
  localparam int LLSC_TAG_W_MAX = 64;

  typedef struct packed {
    logic                      valid;
    logic [LLSC_TID_W_MAX-1:0] tid;
    logic [LLSC_TAG_W_MAX-1:0] tag;
  } llsc_entry_t;

  // LSQ instruction classes as seen by the reservation table.
  localparam llsc_op_t LDQ_L_INST = OP_LL;
  localparam llsc_op_t STQ_C_INST = OP_SC;
  localparam llsc_op_t STQ_INST   = OP_ST;

endpackage

// File: rtl/llsc_resv_table_if.sv
// Request/flush/response bundle between the LSQ commit path (master) and the reservation table (slave).
interface llsc_resv_table_if #(
  parameter int NUM_THREADS = 2,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 64
) ();
  import llsc_pkg::*;

  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int IDX_W = $clog2(DEPTH);

  logic              req_valid;
  llsc_op_t          req_op;
  logic [TID_W-1:0]  req_tid;
  logic [ADDR_W-1:0] req_addr;
  logic              flush_valid;
  logic [TID_W-1:0]  flush_tid;
  logic              resp_valid;
  logic              resp_sc_success;
  logic              resp_evicted;
  logic              full;
  logic [IDX_W:0]    count;

  modport master (
    output req_valid, req_op, req_tid, req_addr, flush_valid, flush_tid,
    input  resp_valid, resp_sc_success, resp_evicted, full, count
  );

  modport slave (
    input  req_valid, req_op, req_tid, req_addr, flush_valid, flush_tid,
    output resp_valid, resp_sc_success, resp_evicted, full, count
  );

endinterface

// File: rtl/llsc_alloc_sel.sv
// Lowest-index priority encoder: picks the first set bit of free_vec.
module llsc_alloc_sel #(
  parameter  int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] free_vec,
  output logic [IDX_W-1:0] free_idx,
  output logic             any_free
);

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_vec[i]) free_idx = IDX_W'(i);
    end
  end

  assign any_free = |free_vec;

endmodule

// File: rtl/llsc_resv_table.sv
// Multi-thread LL/SC reservation table with victim eviction, per-thread flush and registered SC verdict.
// Optional reservation expiry is enabled by defining LLSC_TIMEOUT_EN.
module llsc_resv_table
  import llsc_pkg::*;
#(
  parameter int NUM_THREADS = 2,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 64,
  parameter int GRAN_LSB    = 3,
  parameter int TIMEOUT     = 255
) (
  input logic              clock,
  input logic              reset,
  llsc_resv_table_if.slave bus
);

  localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - GRAN_LSB;

  genvar gi;

  generate
    if (DEPTH < 2 || TIMEOUT < 1 || GRAN_LSB < 1 ||
        TID_W > LLSC_TID_W_MAX || TAG_W > LLSC_TAG_W_MAX) begin : g_bad_cfg
      $error("llsc_resv_table: unsupported parameter combination");
    end
  endgenerate

  llsc_entry_t      entry_reg  [DEPTH];
  llsc_entry_t      entry_next [DEPTH];
  logic [IDX_W-1:0] victim_reg, victim_next;
  logic             resp_valid_reg, resp_sc_reg, resp_evict_reg;

  logic [LLSC_TID_W_MAX-1:0] req_tid_x, flush_tid_x;
  logic [LLSC_TAG_W_MAX-1:0] req_tag_x;
  logic [GRAN_LSB-1:0]       unused_offset;

  assign req_tid_x     = LLSC_TID_W_MAX'(bus.req_tid);
  assign flush_tid_x   = LLSC_TID_W_MAX'(bus.flush_tid);
  assign req_tag_x     = LLSC_TAG_W_MAX'(bus.req_addr[ADDR_W-1:GRAN_LSB]);
  assign unused_offset = bus.req_addr[GRAN_LSB-1:0];

  logic req_act, blocked, ll_go, sc_go, st_go;
  logic [DEPTH-1:0] valid_vec, live, tag_hit, thr_hit, kill, expired;

  assign req_act = bus.req_valid && (bus.req_op != OP_NOP);
  // A flush of the requesting thread suppresses the request's own effect.
  assign blocked = bus.flush_valid && (bus.flush_tid == bus.req_tid);
  assign ll_go   = req_act && (bus.req_op == OP_LL) && !blocked;
  assign sc_go   = req_act && (bus.req_op == OP_SC) && !blocked;
  assign st_go   = req_act && (bus.req_op == OP_ST);

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign valid_vec[gi] = entry_reg[gi].valid;
      assign live[gi]      = entry_reg[gi].valid && !expired[gi];
      assign tag_hit[gi]   = live[gi] && (entry_reg[gi].tag == req_tag_x);
      assign thr_hit[gi]   = tag_hit[gi] && (entry_reg[gi].tid == req_tid_x);
      assign kill[gi]      = expired[gi]
                           || (bus.flush_valid && entry_reg[gi].valid &&
                               (entry_reg[gi].tid == flush_tid_x))
                           || (tag_hit[gi] && (st_go || sc_go));
    end
  endgenerate

  logic [IDX_W-1:0] match_idx, free_idx, wr_idx;
  logic             any_thr, any_free, sc_ok, evict;

  llsc_alloc_sel #(.DEPTH(DEPTH)) u_match_sel (
    .free_vec (thr_hit),
    .free_idx (match_idx),
    .any_free (any_thr)
  );

  llsc_alloc_sel #(.DEPTH(DEPTH)) u_free_sel (
    .free_vec (~live),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  assign sc_ok  = sc_go && any_thr;
  assign evict  = ll_go && !any_thr && !any_free;
  assign wr_idx = any_thr ? match_idx : (any_free ? free_idx : victim_reg);

  // Invalidations first, then the LL write so it can reuse a slot freed this cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_next[i] = entry_reg[i];
      if (kill[i]) entry_next[i].valid = 1'b0;
    end
    if (ll_go) begin
      entry_next[wr_idx].valid = 1'b1;
      entry_next[wr_idx].tid   = req_tid_x;
      entry_next[wr_idx].tag   = req_tag_x;
    end
    victim_next = victim_reg;
    if (evict) begin
      victim_next = (victim_reg == IDX_W'(DEPTH - 1)) ? '0 : victim_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
      victim_reg     <= '0;
      resp_valid_reg <= 1'b0;
      resp_sc_reg    <= 1'b0;
      resp_evict_reg <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= entry_next[i];
      victim_reg     <= victim_next;
      resp_valid_reg <= req_act;
      resp_sc_reg    <= sc_ok;
      resp_evict_reg <= evict;
    end
  end

`ifdef LLSC_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT + 1);

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [AGE_W-1:0] age_reg;

      assign expired[gi] = entry_reg[gi].valid && (age_reg == AGE_W'(TIMEOUT));

      always_ff @(posedge clock) begin
        if (reset) begin
          age_reg <= '0;
        end else if (ll_go && (wr_idx == IDX_W'(gi))) begin
          age_reg <= '0;
        end else if (live[gi]) begin
          age_reg <= age_reg + 1'b1;
        end else begin
          age_reg <= '0;
        end
      end
    end
  endgenerate
`else
  assign expired = '0;
`endif

  logic [IDX_W:0] count_val;

  always_comb begin
    count_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_val = count_val + {{IDX_W{1'b0}}, valid_vec[i]};
    end
  end

  assign bus.resp_valid      = resp_valid_reg;
  assign bus.resp_sc_success = resp_sc_reg;
  assign bus.resp_evicted    = resp_evict_reg;
  assign bus.full            = &valid_vec;
  assign bus.count           = count_val;

endmodule

// File: tb/tb_llsc_resv_table.sv
// Directed bench for llsc_resv_table; the expiry scenario runs when LLSC_TIMEOUT_EN is defined.
module tb_llsc_resv_table;
  import llsc_pkg::*;

  localparam int NT     = 2;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;
  localparam int GRAN   = 3;
  localparam int TID_W  = 1;
`ifdef LLSC_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic clock;
  logic reset;

  llsc_resv_table_if #(.NUM_THREADS(NT), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  llsc_resv_table #(
    .NUM_THREADS (NT),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .GRAN_LSB    (GRAN),
    .TIMEOUT     (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic drive_idle();
    bus.req_valid   = 1'b0;
    bus.req_op      = OP_NOP;
    bus.req_tid     = '0;
    bus.req_addr    = '0;
    bus.flush_valid = 1'b0;
    bus.flush_tid   = '0;
  endtask

  task automatic issue(input logic v, input llsc_op_t op, input logic [TID_W-1:0] tid,
                       input logic [63:0] addr, input logic fv, input logic [TID_W-1:0] ftid);
    bus.req_valid   = v;
    bus.req_op      = op;
    bus.req_tid     = tid;
    bus.req_addr    = addr;
    bus.flush_valid = fv;
    bus.flush_tid   = ftid;
    @(posedge clock);
    #1;
    $display("txn v=%0d op=%s tid=%0d addr=%h flush=%0d/%0d -> rv=%0d sc=%0d ev=%0d count=%0d full=%0d",
             v, op.name(), tid, addr, fv, ftid, bus.resp_valid, bus.resp_sc_success,
             bus.resp_evicted, bus.count, bus.full);
    drive_idle();
  endtask

  task automatic ll(input logic [TID_W-1:0] t, input logic [63:0] a);
    issue(1'b1, LDQ_L_INST, t, a, 1'b0, '0);
  endtask
  task automatic sc(input logic [TID_W-1:0] t, input logic [63:0] a);
    issue(1'b1, STQ_C_INST, t, a, 1'b0, '0);
  endtask
  task automatic st(input logic [TID_W-1:0] t, input logic [63:0] a);
    issue(1'b1, STQ_INST, t, a, 1'b0, '0);
  endtask
  task automatic flush(input logic [TID_W-1:0] t);
    issue(1'b0, OP_NOP, '0, '0, 1'b1, t);
  endtask
  task automatic idle();
    issue(1'b0, OP_NOP, '0, '0, 1'b0, '0);
  endtask

  // At most one reservation per (tid, tag) may ever exist.
  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = i + 1; j < DEPTH; j++) begin
          assert (!(dut.entry_reg[i].valid && dut.entry_reg[j].valid &&
                    dut.entry_reg[i].tid == dut.entry_reg[j].tid &&
                    dut.entry_reg[i].tag == dut.entry_reg[j].tag))
            else $error("duplicate reservation in entries %0d and %0d", i, j);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_sc", bus.resp_sc_success, 0);
    check("rst_evicted", bus.resp_evicted, 0);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    reset = 1'b0;

`ifdef LLSC_TIMEOUT_EN
    ll(0, 64'h500);
    repeat (4) idle();
    check("tmo_count_before", bus.count, 1);
    sc(0, 64'h500);
    check("tmo_rv", bus.resp_valid, 1);
    check("tmo_sc_expired", bus.resp_sc_success, 0);
    check("tmo_count_after", bus.count, 0);
    ll(0, 64'h500);
    idle();
    idle();
    ll(0, 64'h500);
    check("tmo_refresh_count", bus.count, 1);
    idle();
    sc(0, 64'h500);
    check("tmo_sc_refreshed", bus.resp_sc_success, 1);
    check("tmo_count_final", bus.count, 0);
`else
    // Basic LL/SC within one granule.
    ll(0, 64'h1000);
    check("ll_rv", bus.resp_valid, 1);
    check("ll_sc0", bus.resp_sc_success, 0);
    check("ll_count", bus.count, 1);
    sc(0, 64'h1004);
    check("sc_ok", bus.resp_sc_success, 1);
    check("sc_count", bus.count, 0);

    // Plain store from another thread kills the reservation.
    ll(0, 64'h2000);
    st(1, 64'h2000);
    check("st_count", bus.count, 0);
    check("st_sc0", bus.resp_sc_success, 0);
    sc(0, 64'h2000);
    check("st_sc_fail", bus.resp_sc_success, 0);

    // Fill, evict, and confirm the victim pointer ignores plain allocations.
    ll(0, 64'h0);
    ll(0, 64'h8);
    ll(0, 64'h10);
    check("fill_evict0", bus.resp_evicted, 0);
    ll(0, 64'h18);
    check("fill_full", bus.full, 1);
    check("fill_count", bus.count, 4);
    ll(1, 64'h40);
    check("evict_a", bus.resp_evicted, 1);
    check("evict_a_count", bus.count, 4);
    ll(1, 64'h48);
    check("evict_b", bus.resp_evicted, 1);
    sc(0, 64'h0);
    check("evicted_sc0", bus.resp_sc_success, 0);
    sc(0, 64'h10);
    check("survivor_sc", bus.resp_sc_success, 1);
    check("survivor_count", bus.count, 3);
    ll(0, 64'h50);
    check("alloc_no_evict", bus.resp_evicted, 0);
    ll(1, 64'h58);
    check("evict_c", bus.resp_evicted, 1);
    sc(0, 64'h50);
    check("evict_c_sc", bus.resp_sc_success, 0);
    flush(0);
    check("flush0_count", bus.count, 3);
    flush(1);
    check("flush1_count", bus.count, 0);

    // Victim pointer now at DEPTH-1: next two evictions hit entries 3 then 0.
    ll(0, 64'h600);
    ll(0, 64'h608);
    ll(0, 64'h610);
    ll(0, 64'h618);
    ll(1, 64'h700);
    check("wrap_ev3", bus.resp_evicted, 1);
    ll(1, 64'h708);
    check("wrap_ev0", bus.resp_evicted, 1);
    sc(0, 64'h618);
    check("wrap_sc618", bus.resp_sc_success, 0);
    sc(0, 64'h600);
    check("wrap_sc600", bus.resp_sc_success, 0);
    sc(0, 64'h608);
    check("wrap_sc608", bus.resp_sc_success, 1);
    check("wrap_count", bus.count, 3);
    flush(0);
    flush(1);
    check("wrap_clear", bus.count, 0);

    // Cross-thread invalidation by a successful SC.
    ll(0, 64'h100);
    ll(1, 64'h100);
    check("xt_count", bus.count, 2);
    sc(1, 64'h100);
    check("xt_sc1", bus.resp_sc_success, 1);
    check("xt_count0", bus.count, 0);
    sc(0, 64'h100);
    check("xt_sc0", bus.resp_sc_success, 0);

    // Repeated LL refreshes rather than duplicating.
    ll(0, 64'h200);
    ll(0, 64'h200);
    check("refresh_count", bus.count, 1);
    sc(0, 64'h200);
    check("refresh_sc", bus.resp_sc_success, 1);

    // Same-thread flush beats the SC.
    ll(1, 64'h300);
    issue(1'b1, STQ_C_INST, 1, 64'h300, 1'b1, 1);
    check("fl_same_rv", bus.resp_valid, 1);
    check("fl_same_sc", bus.resp_sc_success, 0);
    check("fl_same_count", bus.count, 0);

    // Flush of a different thread alongside an LL: both take effect.
    ll(0, 64'h400);
    issue(1'b1, LDQ_L_INST, 1, 64'h408, 1'b1, 0);
    check("fl_diff_count", bus.count, 1);
    sc(1, 64'h408);
    check("fl_diff_sc", bus.resp_sc_success, 1);

    // Flushed ST still invalidates other threads' matches.
    ll(0, 64'h480);
    ll(1, 64'h480);
    issue(1'b1, STQ_INST, 1, 64'h480, 1'b1, 1);
    check("fl_st_rv", bus.resp_valid, 1);
    check("fl_st_count", bus.count, 0);
    sc(0, 64'h480);
    check("fl_st_sc", bus.resp_sc_success, 0);

    // Reset in the middle of traffic.
    ll(0, 64'h900);
    check("mid_pre_count", bus.count, 1);
    reset = 1'b1;
    ll(1, 64'h908);
    check("mid_rv", bus.resp_valid, 0);
    check("mid_sc", bus.resp_sc_success, 0);
    check("mid_ev", bus.resp_evicted, 0);
    check("mid_full", bus.full, 0);
    check("mid_count", bus.count, 0);
    reset = 1'b0;
    sc(0, 64'h900);
    check("post_rst_sc", bus.resp_sc_success, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
